// File: rtl/tracker_slot_scheduler.sv
// Tracker slot scheduler: allocates trace entries into a small pool of slots,
// issues one memory request per slot (round-robin), collects completions and
// retires slots strictly in allocation order through an age FIFO.
module tracker_slot_scheduler #(
  parameter int SLOTS  = 4,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  // allocation
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [ADDR_W-1:0]          alloc_addr,
  input  logic [IDX_W-1:0]           alloc_index,
  // memory request issue
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [$clog2(SLOTS)-1:0]   mem_req_slot,
  // memory completion
  input  logic                       mem_done_valid,
  input  logic [$clog2(SLOTS)-1:0]   mem_done_slot,
  // in-order retirement
  output logic                       retire_valid,
  input  logic                       retire_ready,
  output logic [ADDR_W-1:0]          retire_addr,
  output logic [IDX_W-1:0]           retire_index,
  // address lookup and status
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [$clog2(SLOTS):0]     occupancy,
  output logic                       protocol_err
);

  localparam int SW = $clog2(SLOTS);
  localparam int CW = SW + 1;

  localparam logic [1:0] ST_FREE         = 2'd0;
  localparam logic [1:0] ST_MAKE_REQUEST = 2'd1;
  localparam logic [1:0] ST_WAIT         = 2'd2;
  localparam logic [1:0] ST_RETIRED      = 2'd3;

  // per-slot storage
  logic [1:0]        state_q [SLOTS];
  logic [1:0]        state_d [SLOTS];
  logic [SLOTS-1:0]  occ_q, occ_d;
  logic [ADDR_W-1:0] addr_q  [SLOTS];
  logic [ADDR_W-1:0] addr_d  [SLOTS];
  logic [IDX_W-1:0]  idx_q   [SLOTS];
  logic [IDX_W-1:0]  idx_d   [SLOTS];

  // age FIFO of slot ids; its count doubles as the occupancy count since
  // every non-free slot has exactly one entry in it
  logic [SW-1:0]     fifo_q  [SLOTS];
  logic [SW-1:0]     fifo_d  [SLOTS];
  logic [SW-1:0]     head_q, head_d;
  logic [SW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // arbitration state
  logic [SW-1:0]     rr_q, rr_d;
  logic              lock_q, lock_d;
  logic [SW-1:0]     lock_slot_q, lock_slot_d;
  logic              err_q, err_d;

  // decoded per-cycle information
  logic              free_any;
  logic [SW-1:0]     free_slot;
  logic              mkreq_any;
  logic [SW-1:0]     rr_slot;
  logic [SW-1:0]     gnt_slot;
  logic [SW-1:0]     head_slot;
  logic              alloc_fire;
  logic              gnt_fire;
  logic              retire_fire;
  logic              done_ok;

  // lowest-numbered free slot from registered state
  always_comb begin
    free_any  = 1'b0;
    free_slot = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!free_any && state_q[i] == ST_FREE) begin
        free_any  = 1'b1;
        free_slot = SW'(i);
      end
    end
  end

  // round-robin search for a requesting slot, starting after the last grant
  always_comb begin
    logic [SW-1:0] cand;
    mkreq_any = 1'b0;
    rr_slot   = rr_q;
    cand      = '0;
    for (int unsigned k = 1; k <= SLOTS; k++) begin
      cand = rr_q + SW'(k);
      if (!mkreq_any && state_q[cand] == ST_MAKE_REQUEST) begin
        mkreq_any = 1'b1;
        rr_slot   = cand;
      end
    end
  end

  // handshake decode; a stalled grant is pinned so a newly requesting slot
  // that round-robin would prefer cannot displace it before acceptance
  always_comb begin
    gnt_slot      = lock_q ? lock_slot_q : rr_slot;
    head_slot     = fifo_q[head_q];
    alloc_ready   = free_any;
    mem_req_valid = mkreq_any;
    mem_req_slot  = gnt_slot;
    mem_req_addr  = addr_q[gnt_slot];
    retire_valid  = (cnt_q != '0) && (state_q[head_slot] == ST_RETIRED);
    retire_addr   = addr_q[head_slot];
    retire_index  = idx_q[head_slot];
    occupancy     = cnt_q;
    protocol_err  = err_q;
    alloc_fire    = alloc_valid && free_any;
    gnt_fire      = mkreq_any && mem_req_ready;
    retire_fire   = retire_valid && retire_ready;
    done_ok       = mem_done_valid && (state_q[mem_done_slot] == ST_WAIT);
  end

  // zero-latency address match over occupied slots
  always_comb begin
    lookup_hit = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (occ_q[i] && addr_q[i] == lookup_addr) begin
        lookup_hit = 1'b1;
      end
    end
  end

  // next-state: the four events always target distinct slots because each
  // one requires a different registered slot state
  always_comb begin
    state_d     = state_q;
    occ_d       = occ_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    lock_d      = mkreq_any && !mem_req_ready;
    lock_slot_d = gnt_slot;
    err_d       = err_q | (mem_done_valid && !done_ok);

    if (alloc_fire) begin
      state_d[free_slot] = ST_MAKE_REQUEST;
      occ_d[free_slot]   = 1'b1;
      addr_d[free_slot]  = alloc_addr;
      idx_d[free_slot]   = alloc_index;
      fifo_d[tail_q]     = free_slot;
      tail_d             = tail_q + 1'b1;
    end
    if (gnt_fire) begin
      state_d[gnt_slot] = ST_WAIT;
      rr_d              = gnt_slot;
    end
    if (done_ok) begin
      state_d[mem_done_slot] = ST_RETIRED;
    end
    if (retire_fire) begin
      state_d[head_slot] = ST_FREE;
      occ_d[head_slot]   = 1'b0;
      head_d             = head_q + 1'b1;
    end
    case ({alloc_fire, retire_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        state_q[i] <= ST_FREE;
        addr_q[i]  <= '0;
        idx_q[i]   <= '0;
        fifo_q[i]  <= '0;
      end
      occ_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      rr_q        <= '1;
      lock_q      <= 1'b0;
      lock_slot_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_slot_q <= lock_slot_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_tracker_slot_scheduler.sv
// Bench for tracker_slot_scheduler: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// slot-list / age-queue model.
module tb_tracker_slot_scheduler;

  localparam int SLOTS = 4;
  localparam int AW    = 32;
  localparam int IW    = 17;
  localparam int SW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [AW-1:0] alloc_addr = '0;
  logic [IW-1:0] alloc_index = '0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic [SW-1:0] mem_req_slot;
  logic          mem_done_valid = 1'b0;
  logic [SW-1:0] mem_done_slot = '0;
  logic          retire_valid;
  logic          retire_ready = 1'b0;
  logic [AW-1:0] retire_addr;
  logic [IW-1:0] retire_index;
  logic [AW-1:0] lookup_addr = '0;
  logic          lookup_hit;
  logic [SW:0]   occupancy;
  logic          protocol_err;

  tracker_slot_scheduler #(.SLOTS(SLOTS), .ADDR_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_addr(alloc_addr), .alloc_index(alloc_index),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_slot(mem_req_slot),
    .mem_done_valid(mem_done_valid), .mem_done_slot(mem_done_slot),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .retire_addr(retire_addr), .retire_index(retire_index),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .occupancy(occupancy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef enum int {M_FREE, M_MKREQ, M_WAIT, M_DONE} mst_t;
  mst_t          ms    [SLOTS];
  logic [AW-1:0] maddr [SLOTS];
  logic [IW-1:0] midx  [SLOTS];
  int            age_q [$];
  int            last_gnt;
  int            held;
  bit            merr;
  bit            model_ok = 1'b0;

  function automatic bit m_alloc_ready();
    for (int i = 0; i < SLOTS; i++) if (ms[i] == M_FREE) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_free_slot();
    for (int i = 0; i < SLOTS; i++) if (ms[i] == M_FREE) return i;
    return -1;
  endfunction

  function automatic bit m_req_valid();
    for (int i = 0; i < SLOTS; i++) if (ms[i] == M_MKREQ) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_gnt();
    if (held >= 0) return held;
    for (int i = 1; i <= SLOTS; i++)
      if (ms[(last_gnt + i) % SLOTS] == M_MKREQ) return (last_gnt + i) % SLOTS;
    return 0;
  endfunction

  function automatic bit m_ret_valid();
    return (age_q.size() != 0) && (ms[age_q[0]] == M_DONE);
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (ms[i] != M_FREE) n++;
    return n;
  endfunction

  function automatic bit m_hit(input logic [AW-1:0] a);
    for (int i = 0; i < SLOTS; i++) if (ms[i] != M_FREE && maddr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  bit mu_a, mu_g, mu_r, mu_d, mu_rv;
  int mu_fs, mu_gs, mu_hs;

  // model advances on the same edge as the DUT, from the same inputs
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        ms[i] = M_FREE; maddr[i] = '0; midx[i] = '0;
      end
      age_q.delete();
      last_gnt = SLOTS - 1;
      held     = -1;
      merr     = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      mu_a  = alloc_valid && m_alloc_ready();
      mu_fs = m_free_slot();
      mu_rv = m_req_valid();
      mu_gs = m_gnt();
      mu_g  = mu_rv && mem_req_ready;
      mu_r  = m_ret_valid() && retire_ready;
      mu_hs = (age_q.size() != 0) ? age_q[0] : 0;
      mu_d  = mem_done_valid && (ms[mem_done_slot] == M_WAIT);
      if (mem_done_valid && !mu_d) merr = 1'b1;
      held = (mu_rv && !mem_req_ready) ? mu_gs : -1;
      if (mu_g) begin ms[mu_gs] = M_WAIT; last_gnt = mu_gs; end
      if (mu_d) ms[mem_done_slot] = M_DONE;
      if (mu_r) begin ms[mu_hs] = M_FREE; void'(age_q.pop_front()); end
      if (mu_a) begin
        ms[mu_fs] = M_MKREQ; maddr[mu_fs] = alloc_addr; midx[mu_fs] = alloc_index;
        age_q.push_back(mu_fs);
      end
    end
  end

  // ---------------- checking ----------------
  typedef enum int {S_AR, S_RQV, S_RQS, S_RQA, S_RTV, S_RTI, S_RTA, S_HIT, S_OCC, S_ERR} sig_t;
  typedef struct {
    string       name;
    sig_t        sig;
    logic [63:0] exp;
  } lit_t;
  lit_t lit_q [$];
  lit_t cur_lit;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [63:0] get_sig(input sig_t s);
    case (s)
      S_AR:    return 64'(alloc_ready);
      S_RQV:   return 64'(mem_req_valid);
      S_RQS:   return 64'(mem_req_slot);
      S_RQA:   return 64'(mem_req_addr);
      S_RTV:   return 64'(retire_valid);
      S_RTI:   return 64'(retire_index);
      S_RTA:   return 64'(retire_addr);
      S_HIT:   return 64'(lookup_hit);
      S_OCC:   return 64'(occupancy);
      default: return 64'(protocol_err);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // single compare process: model expectations every cycle plus queued literals
  always @(negedge clk) begin
    if (model_ok) begin
      check("alloc_ready", 64'(alloc_ready), 64'(m_alloc_ready()));
      check("mem_req_valid", 64'(mem_req_valid), 64'(m_req_valid()));
      if (m_req_valid()) begin
        check("mem_req_slot", 64'(mem_req_slot), 64'(m_gnt()));
        check("mem_req_addr", 64'(mem_req_addr), 64'(maddr[m_gnt()]));
      end
      check("retire_valid", 64'(retire_valid), 64'(m_ret_valid()));
      if (m_ret_valid()) begin
        check("retire_addr", 64'(retire_addr), 64'(maddr[age_q[0]]));
        check("retire_index", 64'(retire_index), 64'(midx[age_q[0]]));
      end
      check("lookup_hit", 64'(lookup_hit), 64'(m_hit(lookup_addr)));
      check("occupancy", 64'(occupancy), 64'(m_occ()));
      check("protocol_err", 64'(protocol_err), 64'(merr));
      while (lit_q.size() != 0) begin
        cur_lit = lit_q.pop_front();
        check(cur_lit.name, get_sig(cur_lit.sig), cur_lit.exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic expect_lit(input string name, input sig_t s, input logic [63:0] e);
    lit_t l;
    l.name = name; l.sig = s; l.exp = e;
    lit_q.push_back(l);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_valid = 1'b0; mem_req_ready = 1'b0; mem_done_valid = 1'b0;
    retire_ready = 1'b0; mem_done_slot = '0;
  endtask

  task automatic pick_done(input int pct_valid, input int pct_bogus);
    int waits [$];
    int r;
    waits.delete();
    for (int i = 0; i < SLOTS; i++) if (ms[i] == M_WAIT) waits.push_back(i);
    r = $urandom_range(0, 99);
    mem_done_valid = 1'b0;
    if (r < pct_valid && waits.size() != 0) begin
      mem_done_valid = 1'b1;
      mem_done_slot  = SW'(waits[$urandom_range(0, waits.size() - 1)]);
    end else if (r >= 100 - pct_bogus) begin
      mem_done_valid = 1'b1;
      mem_done_slot  = SW'($urandom_range(0, SLOTS - 1));
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && m_occ() != 0; c++) begin
      alloc_valid = 1'b0; mem_req_ready = 1'b1; retire_ready = 1'b1;
      pick_done(100, 0);
      cyc();
    end
    clr();
    expect_lit("drain_empty", S_OCC, 0);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    expect_lit("rst_alloc_ready", S_AR, 1);
    expect_lit("rst_req_valid", S_RQV, 0);
    expect_lit("rst_retire_valid", S_RTV, 0);
    expect_lit("rst_occupancy", S_OCC, 0);
    expect_lit("rst_lookup_hit", S_HIT, 0);
    expect_lit("rst_protocol_err", S_ERR, 0);

    // single entry end to end
    alloc_valid = 1'b1; alloc_addr = 32'h100; alloc_index = 17'd5; mem_req_ready = 1'b1;
    cyc();
    alloc_valid = 1'b0;
    expect_lit("t1_req_valid", S_RQV, 1);
    expect_lit("t1_req_slot", S_RQS, 0);
    expect_lit("t1_req_addr", S_RQA, 64'h100);
    expect_lit("t1_occupancy", S_OCC, 1);
    cyc();
    mem_req_ready = 1'b0; mem_done_valid = 1'b1; mem_done_slot = 2'd0;
    expect_lit("t1_no_retire_yet", S_RTV, 0);
    cyc();
    mem_done_valid = 1'b0;
    expect_lit("t1_retire_valid", S_RTV, 1);
    expect_lit("t1_retire_index", S_RTI, 5);
    expect_lit("t1_retire_addr", S_RTA, 64'h100);
    retire_ready = 1'b1;
    cyc();
    retire_ready = 1'b0;
    expect_lit("t1_occ_after", S_OCC, 0);
    expect_lit("t1_retire_gone", S_RTV, 0);

    // fill all slots, then retire while allocation is held
    for (int i = 0; i < SLOTS; i++) begin
      alloc_valid = 1'b1; alloc_addr = 32'h200 + 32'(i * 16); alloc_index = IW'(10 + i);
      cyc();
    end
    alloc_valid = 1'b0;
    expect_lit("t2_full_ready", S_AR, 0);
    expect_lit("t2_full_occ", S_OCC, 4);
    mem_req_ready = 1'b1;
    for (int i = 0; i < SLOTS; i++) cyc();
    mem_req_ready = 1'b0;
    expect_lit("t2_all_granted", S_RQV, 0);
    mem_done_valid = 1'b1; mem_done_slot = 2'd0;
    cyc();
    mem_done_valid = 1'b0;
    expect_lit("t2_head_retire", S_RTI, 10);
    alloc_valid = 1'b1; alloc_addr = 32'h300; alloc_index = 17'd20; retire_ready = 1'b1;
    expect_lit("t2_not_ready_yet", S_AR, 0);
    cyc();
    retire_ready = 1'b0;
    expect_lit("t2_ready_after_retire", S_AR, 1);
    expect_lit("t2_occ_after_retire", S_OCC, 3);
    cyc();
    alloc_valid = 1'b0;
    lookup_addr = 32'h300;
    expect_lit("t2_occ_refilled", S_OCC, 4);
    expect_lit("t2_lookup_new", S_HIT, 1);
    drain();

    // stalled grant stays put, then round-robin order
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_addr = 32'h400 + 32'(i * 16); alloc_index = IW'(30 + i);
      cyc();
    end
    alloc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_lit("t3_hold_slot", S_RQS, 0);
      expect_lit("t3_hold_addr", S_RQA, 64'h400);
      cyc();
    end
    mem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_lit("t3_rr_order", S_RQS, 64'(k));
      cyc();
    end
    mem_req_ready = 1'b0;
    expect_lit("t3_req_idle", S_RQV, 0);

    // out-of-order completion, in-order retirement
    mem_done_valid = 1'b1; mem_done_slot = 2'd1;
    cyc();
    mem_done_valid = 1'b0;
    expect_lit("t4_blocked", S_RTV, 0);
    cyc();
    expect_lit("t4_still_blocked", S_RTV, 0);
    mem_done_valid = 1'b1; mem_done_slot = 2'd0; retire_ready = 1'b1;
    cyc();
    mem_done_valid = 1'b0;
    expect_lit("t4_first_valid", S_RTV, 1);
    expect_lit("t4_first_index", S_RTI, 30);
    cyc();
    expect_lit("t4_second_valid", S_RTV, 1);
    expect_lit("t4_second_index", S_RTI, 31);
    cyc();
    retire_ready = 1'b0;
    expect_lit("t4_done", S_RTV, 0);
    expect_lit("t4_occ", S_OCC, 1);

    // bogus completion on a free slot, then reset with work in flight
    mem_req_ready = 1'b1;
    alloc_valid = 1'b1; alloc_addr = 32'h500; alloc_index = 17'd40;
    cyc();
    alloc_addr = 32'h510; alloc_index = 17'd41;
    cyc();
    alloc_valid = 1'b0;
    cyc();
    mem_req_ready = 1'b0;
    mem_done_valid = 1'b1; mem_done_slot = 2'd3;
    cyc();
    mem_done_valid = 1'b0;
    expect_lit("t5_err_set", S_ERR, 1);
    expect_lit("t5_occ_same", S_OCC, 3);
    cyc();
    lookup_addr = 32'h420;
    expect_lit("t5_err_sticky", S_ERR, 1);
    expect_lit("t5_lookup_before", S_HIT, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    expect_lit("t6_occ", S_OCC, 0);
    expect_lit("t6_retire", S_RTV, 0);
    expect_lit("t6_lookup", S_HIT, 0);
    expect_lit("t6_err", S_ERR, 0);
    expect_lit("t6_alloc_ready", S_AR, 1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      alloc_valid   = ($urandom_range(0, 99) < 60);
      alloc_addr    = 32'($urandom_range(0, 15)) << 4;
      alloc_index   = IW'($urandom);
      mem_req_ready = ($urandom_range(0, 99) < 55);
      retire_ready  = ($urandom_range(0, 99) < 65);
      lookup_addr   = 32'($urandom_range(0, 15)) << 4;
      pick_done(60, 3);
      cyc();
    end
    rst = 1'b0;
    clr();
    cyc(); cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
